pattern_scan_ctrl: RTL and testbench

Hardware sequencer for the program-3 pattern-count task, so the core can offload the scan. On Start it reads the 5-bit pattern and the 32-byte message from data memory. It computes three counts: in-byte occurrences, bytes containing at least one occurrence, and occurrences including byte crossings. It writes the counts back to data memory and raises Ack.

---
 rtl/pattern_scan_ctrl_if.sv | 8 +
 rtl/pattern_scan_ctrl.sv | 108 ++++++++++
 tb/tb_pattern_scan_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pattern_scan_ctrl_if.sv
// pattern_scan_ctrl_if: start/ack handshake and data-memory bus of the pattern scan sequencer
interface pattern_scan_ctrl_if #(parameter int AW = 8);
  logic start, ack, busy, mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [7:0] mem_rd_data, mem_wr_data;
  modport master (output mem_addr, mem_wr_en, mem_wr_data, ack, busy, input start, mem_rd_data);
  modport slave (input mem_addr, mem_wr_en, mem_wr_data, ack, busy, output start, mem_rd_data);
endinterface

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: scans a message for a 5-bit pattern and writes in-byte, bytes-hit and crossing counts
module pattern_scan_ctrl #(
  parameter int AW = 8,
  parameter int BASE_ADDR = 0,
  parameter int LEN = 32,
  parameter int PAT_ADDR = 32,
  parameter int RES_ADDR = 33
) (
  input logic clk,
  input logic rst_n,
  pattern_scan_ctrl_if.master bus
);
  localparam int IW = $clog2(LEN);
  typedef enum logic [2:0] {IDLE, LOAD_PAT, SCAN, WR0, WR1, WR2, DONE} state_t;
  state_t state;
  logic [4:0] pat;
  logic [7:0] prev, ctb, cto, cts, ctb_n, cto_n, cts_n, wr_data;
  logic [IW-1:0] i;
  logic [15:0] w16;
  logic [3:0] in_m, cr_m;
  logic [AW-1:0] addr;
  logic ack, busy, wr_en;
  assign bus.mem_addr = addr;
  assign bus.mem_wr_en = wr_en;
  assign bus.mem_wr_data = wr_data;
  assign bus.ack = ack;
  assign bus.busy = busy;
  always_comb begin
    w16 = {prev, bus.mem_rd_data};
    in_m = '0;
    cr_m = '0;
    for (int k = 0; k < 4; k++) begin
      in_m = in_m + 4'(w16[k+:5] == pat);
      cr_m = cr_m + 4'(w16[k+4+:5] == pat && i != '0);
    end
    ctb_n = ctb + 8'(in_m);
    cto_n = cto + 8'(in_m != '0);
    cts_n = cts + 8'(in_m) + 8'(cr_m);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pat <= '0;
      prev <= '0;
      i <= '0;
      ctb <= '0;
      cto <= '0;
      cts <= '0;
      addr <= '0;
      wr_en <= 1'b0;
      wr_data <= '0;
      ack <= 1'b0;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (bus.start) begin
          state <= LOAD_PAT;
          ctb <= '0;
          cto <= '0;
          cts <= '0;
          ack <= 1'b0;
          busy <= 1'b1;
          addr <= AW'(PAT_ADDR);
        end
        LOAD_PAT: begin
          state <= SCAN;
          pat <= bus.mem_rd_data[7:3];
          prev <= '0;
          i <= '0;
          addr <= AW'(BASE_ADDR);
        end
        SCAN: begin
          prev <= bus.mem_rd_data;
          i <= i + 1'b1;
          ctb <= ctb_n;
          cto <= cto_n;
          cts <= cts_n;
          // the final byte's contribution goes straight into the first write
          if (i == IW'(LEN - 1)) begin
            state <= WR0;
            addr <= AW'(RES_ADDR);
            wr_en <= 1'b1;
            wr_data <= ctb_n;
          end else addr <= AW'(BASE_ADDR) + AW'(i) + AW'(1);
        end
        WR0: begin
          state <= WR1;
          addr <= AW'(RES_ADDR + 1);
          wr_data <= cto;
        end
        WR1: begin
          state <= WR2;
          addr <= AW'(RES_ADDR + 2);
          wr_data <= cts;
        end
        WR2: begin
          state <= DONE;
          addr <= '0;
          wr_en <= 1'b0;
          wr_data <= '0;
          busy <= 1'b0;
          ack <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb_pattern_scan_ctrl: directed and random runs checked against a bit-stream reference model
module tb_pattern_scan_ctrl;
  localparam int LEN = 32;
  logic clk = 0, rst_n = 1, clr = 0;
  always #5 clk = ~clk;
  pattern_scan_ctrl_if #(.AW(8)) bus();
  pattern_scan_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [7:0] mem [256];
  logic [7:0] res [3];
  logic [15:0] wq [$];
  int checks = 0, errors = 0;
  int a, b, c;
  assign bus.mem_rd_data = mem[bus.mem_addr];
  always @(posedge clk)
    if (clr) begin
      res[0] <= 8'h0;
      res[1] <= 8'h0;
      res[2] <= 8'h0;
    end else if (bus.mem_wr_en && bus.mem_addr >= 8'd33 && bus.mem_addr <= 8'd35)
      res[2'(bus.mem_addr - 8'd33)] <= bus.mem_wr_data;
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask
  // every write must be one that the model predicted, in order
  always @(negedge clk) if (rst_n) begin
    chk("ack_busy_exclusive", int'(bus.ack & bus.busy), 0);
    if (bus.mem_wr_en) begin
      chk("wr_en_while_busy", int'(bus.busy), 1);
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write addr %0d data %0d expected none", bus.mem_addr, bus.mem_wr_data);
      end else begin
        logic [15:0] e;
        e = wq.pop_front();
        chk("write_addr", int'(bus.mem_addr), int'(e[15:8]));
        chk("write_data", int'(bus.mem_wr_data), int'(e[7:0]));
      end
    end
  end
  function automatic void model(input logic [7:0] pb, output int ra, output int rb, output int rc);
    logic s [8*LEN];
    bit hit [LEN];
    int v;
    ra = 0;
    rb = 0;
    rc = 0;
    for (int j = 0; j < LEN; j++) begin
      hit[j] = 0;
      for (int t = 0; t < 8; t++) s[j*8+t] = mem[j][7-t];
    end
    for (int q = 0; q <= 8*LEN-5; q++) begin
      v = 0;
      for (int u = 0; u < 5; u++) v = v * 2 + int'(s[q+u]);
      if (v == int'(pb[7:3])) begin
        rc++;
        if (q / 8 == (q + 4) / 8) begin
          ra++;
          hit[q/8] = 1;
        end
      end
    end
    for (int j = 0; j < LEN; j++) rb += int'(hit[j]);
  endfunction
  task automatic clear_res();
    @(posedge clk);
    #1 clr = 1;
    @(posedge clk);
    #1 clr = 0;
  endtask
  task automatic run(input logic [7:0] pb, input int hold, output int ra, output int rb, output int rc);
    int n;
    mem[32] = pb;
    model(pb, ra, rb, rc);
    wq.push_back({8'd33, 8'(ra)});
    wq.push_back({8'd34, 8'(rb)});
    wq.push_back({8'd35, 8'(rc)});
    clear_res();
    bus.start = 1;
    @(posedge clk);
    #1;
    chk("ack_drop_after_start", int'(bus.ack), 0);
    chk("busy_after_start", int'(bus.busy), 1);
    bus.start = (hold > 0);
    for (n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      bus.start = (n < hold) || (hold > 0 && n == 20);
      if (bus.ack) break;
    end
    bus.start = 0;
    chk("ack_latency", n, 36);
    repeat (3) @(posedge clk);
    #1;
    chk("ack_hold", int'(bus.ack), 1);
    chk("busy_done", int'(bus.busy), 0);
    chk("res_inbyte", int'(res[0]), ra);
    chk("res_byteshit", int'(res[1]), rb);
    chk("res_crossing", int'(res[2]), rc);
    chk("write_queue_drained", wq.size(), 0);
  endtask
  initial begin
    bus.start = 0;
    for (int j = 0; j < 256; j++) mem[j] = 8'h00;
    #2 rst_n = 0;
    #1;
    chk("rst_ack", int'(bus.ack), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_wr_en", int'(bus.mem_wr_en), 0);
    chk("rst_addr", int'(bus.mem_addr), 0);
    chk("rst_wr_data", int'(bus.mem_wr_data), 0);
    #20 rst_n = 1;
    run(8'h00, 0, a, b, c);
    chk("lit_zero_a", a, 128);
    chk("lit_zero_b", b, 32);
    chk("lit_zero_c", c, 252);
    for (int j = 0; j < LEN; j++) mem[j] = 8'h55;
    run(8'hA8, 0, a, b, c);
    chk("lit_55_a", a, 64);
    chk("lit_55_b", b, 32);
    chk("lit_55_c", c, 126);
    run(8'hF8, 0, a, b, c);
    chk("lit_55f_sum", a + b + c, 0);
    for (int j = 0; j < LEN; j++) mem[j] = 8'h00;
    mem[5] = 8'hF8;
    run(8'hF8, 0, a, b, c);
    chk("lit_single_a", a, 1);
    chk("lit_single_b", b, 1);
    chk("lit_single_c", c, 1);
    mem[5] = 8'h00;
    mem[3] = 8'h03;
    mem[4] = 8'hE0;
    run(8'hF8, 0, a, b, c);
    chk("lit_cross_a", a, 0);
    chk("lit_cross_b", b, 0);
    chk("lit_cross_c", c, 1);
    clear_res();
    bus.start = 1;
    @(posedge clk);
    #1 bus.start = 0;
    repeat (11) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("abort_ack", int'(bus.ack), 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_wr_en", int'(bus.mem_wr_en), 0);
    #3 rst_n = 1;
    repeat (45) @(posedge clk);
    #1;
    chk("abort_res_inbyte", int'(res[0]), 0);
    chk("abort_res_crossing", int'(res[2]), 0);
    chk("abort_idle_ack", int'(bus.ack), 0);
    run(8'hF8, 0, a, b, c);
    for (int j = 0; j < LEN; j++) mem[j] = 8'(j * 37 + 11);
    run(8'h68, 10, a, b, c);
    for (int r = 0; r < 100; r++) begin
      for (int j = 0; j < LEN; j++) mem[j] = 8'($urandom_range(0, 255));
      run(8'($urandom_range(0, 255)), 0, a, b, c);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
